edge_event_scheduler: RTL and testbench
=======================================

Name: edge_event_scheduler

Overview:
Watches N_CH level inputs and detects a rising edge on each one, two flops per channel.
Each channel keeps a count of edges not yet delivered. A round-robin scheduler hands those pending events, one per transfer, to a single downstream consumer over a valid/ready handshake.
The block sits between raw synchronous event lines (buttons, strobes, status bits) and a shared event handler. It makes sure no edge is lost while the handler is busy, and that no channel starves.

Parameters:
N_CH, 4, number of input channels (2..16)
CNT_W, 4, width of each channel's pending-event counter; it saturates at 2^CNT_W-1
CH_W, $clog2(N_CH), width of the channel index (derived; not to be overridden)

Ports:
clk  input  1  clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
sig_in  input  N_CH  event lines, already synchronous to clk
ch_en  input  N_CH  per-channel capture enable
evt_valid  output  1  an event is being offered
evt_ch  output  CH_W  channel index of the offered event
evt_ready  input  1  consumer accepts the offered event
pending_any  output  1  OR of all counters being non-zero (registered)
overflow  output  N_CH  sticky flag per channel: an edge was lost to saturation
ovf_clr  input  N_CH  per-channel clear pulse for overflow

Behaviour:
- Reset (reset=1 at a clk edge): all delay flops, counters, overflow, evt_valid, evt_ch, pending_any and rr_ptr go to 0; FSM goes to IDLE. Reset overrides every other input, including in the middle of an offer (the offer is dropped, not delivered).
- Edge detection, per channel i:
  - d0[i] <= sig_in[i]; d1[i] <= d0[i].
  - edge[i] = d0[i] & ~d1[i] & ch_en[i], where ch_en is sampled in the same cycle as the edge term.
  - After reset, a line held high produces exactly one edge.
- Counter, per channel:
  - inc = edge[i]; dec = this channel is granted in this cycle (see FSM).
  - inc and dec together: count unchanged.
  - inc only, count < max: +1.
  - inc only, count = max: count stays, overflow[i] <= 1.
  - dec only: -1. A decrement at count 0 is impossible by construction; verification asserts it never happens.
- Overflow: set has priority over ovf_clr in the same cycle.
- Channels with ch_en=0 keep their existing count and are still scheduled. Only new edges are dropped, and dropped edges do not set overflow.
- FSM, state IDLE:
  - If any count is non-zero, grant the first non-zero channel searching upward from rr_ptr, modulo N_CH.
  - At that edge: evt_valid<=1, evt_ch<=granted channel, decrement that counter, rr_ptr<=(granted+1) mod N_CH, go to OFFER.
- FSM, state OFFER:
  - evt_valid and evt_ch stay stable until evt_valid & evt_ready.
  - On the handshake edge, if any count is non-zero (the value before this cycle's increments), grant again the same way and stay in OFFER. This allows back-to-back transfers, one per cycle.
  - On the handshake edge with no counts non-zero: evt_valid<=0, go to IDLE.
- Arbitration uses registered counts only. An edge counted in the current cycle becomes eligible in the next cycle.
- Latency: sig_in first sampled high at edge k -> d0=1 after k -> count=1 after k+1 -> evt_valid=1 after k+2 (block idle, no other channels pending).
- pending_any is registered from the post-update counts. It does not include the event currently being offered.

Optional Feature:
Macro: EDGE_SCHED_BOTH_EDGES_EN.
- Defined: edge[i] = (d0[i] ^ d1[i]) & ch_en[i], so both rising and falling transitions are counted. Ports are unchanged.
- Not defined: rising edges only, as described above.

Test Plan:
- Reset, then sig_in[2] 0->1 at edge 5, evt_ready=1 -> evt_valid high after edge 7 with evt_ch=2 for one cycle; then IDLE, pending_any=0.
- evt_ready=0; three pulses of sig_in[0] (high 1 cycle, low 2 cycles) -> one offer evt_ch=0 held stable; raise evt_ready -> three consecutive single-cycle transfers on ch 0, then evt_valid=0.
- All four channels rise in the same cycle, evt_ready=1 -> evt_ch sequence 0,1,2,3 back-to-back; with a further simultaneous rise, the next sequence starts at 0 (rr_ptr wrapped).
- CNT_W=2, evt_ready=0, five edges on ch 1 -> one offered and 3 pending, the fifth edge sets overflow[1]; ovf_clr[1] pulse -> overflow[1]=0; ovf_clr coinciding with a new saturating edge -> overflow[1] stays 1.
- ch_en[3]=0 with an edge on ch 3 -> no event; ch 3 already pending, then ch_en[3]=0 -> its pending event is still delivered.
- reset asserted while in OFFER with counts 2 -> next cycle evt_valid=0, all counts 0; a line held high through reset gives exactly one event after release.

Source files
------------

// File: rtl/edge_event_scheduler.sv
// ----------------------------------------------------------------------------
// edge_event_scheduler
//
// Purpose:
//   Detects edges on N_CH synchronous level inputs and keeps a saturating
//   per-channel count of edges that have not been delivered yet. A
//   round-robin scheduler hands the pending events, one per transfer, to a
//   single consumer over a valid/ready handshake. No edge is lost while the
//   consumer is busy unless a counter saturates, which raises a sticky
//   overflow flag. Every pending channel is reached in turn, so none starves.
//
// Build option:
//   EDGE_SCHED_BOTH_EDGES_EN - when defined, both rising and falling
//   transitions are counted. When undefined, only rising edges are counted.
//
// Ports:
//   clk          clock; all logic on the rising edge
//   reset        synchronous, active-high reset
//   sig_in       [N_CH]  event lines, already synchronous to clk
//   ch_en        [N_CH]  per-channel capture enable for new edges
//   evt_valid    event offered to the consumer
//   evt_ch       [CH_W]  channel index of the offered event
//   evt_ready    consumer accepts the offered event
//   pending_any  registered OR of all counters being non-zero
//   overflow     [N_CH]  sticky flag: an edge was lost to saturation
//   ovf_clr      [N_CH]  per-channel clear pulse for overflow
// ----------------------------------------------------------------------------
module edge_event_scheduler #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 4,
  parameter int CH_W  = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] sig_in,
  input  logic [N_CH-1:0] ch_en,
  output logic            evt_valid,
  output logic [CH_W-1:0] evt_ch,
  input  logic            evt_ready,
  output logic            pending_any,
  output logic [N_CH-1:0] overflow,
  input  logic [N_CH-1:0] ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(N_CH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Edge detection pipeline
  logic [N_CH-1:0] d0_reg;
  logic [N_CH-1:0] d1_reg;
  logic [N_CH-1:0] edge_det;

  // Pending-event counters
  logic [CNT_W-1:0] cnt_reg  [N_CH];
  logic [CNT_W-1:0] cnt_next [N_CH];
  logic [N_CH-1:0]  cnt_nz;
  logic [N_CH-1:0]  dec;
  logic [N_CH-1:0]  ovf_set;
  logic [N_CH-1:0]  overflow_reg;
  logic             pending_next;
  logic             pending_any_reg;

  // Scheduler
  state_t          state_reg;
  logic            evt_valid_reg;
  logic [CH_W-1:0] evt_ch_reg;
  logic [CH_W-1:0] rr_ptr_reg;
  logic            grant_found;
  logic [CH_W-1:0] grant_idx;
  logic [CH_W-1:0] grant_idx_inc;
  logic [CH_W-1:0] search_idx;
  logic            grant_allowed;
  logic            do_grant;

  assign evt_valid   = evt_valid_reg;
  assign evt_ch      = evt_ch_reg;
  assign overflow    = overflow_reg;
  assign pending_any = pending_any_reg;

  // Per-channel edge term, non-zero flag and grant decode
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
`ifdef EDGE_SCHED_BOTH_EDGES_EN
      assign edge_det[gi] = (d0_reg[gi] ^ d1_reg[gi]) & ch_en[gi];
`else
      assign edge_det[gi] = d0_reg[gi] & ~d1_reg[gi] & ch_en[gi];
`endif
      assign cnt_nz[gi] = (cnt_reg[gi] != '0);
      assign dec[gi]    = do_grant && (grant_idx == CH_W'(gi));
    end
  endgenerate

  // Round-robin search: first non-zero registered count at or above rr_ptr,
  // wrapping modulo N_CH. Counts updated this cycle are not visible here,
  // so a fresh edge becomes eligible one cycle after it is counted.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    search_idx  = '0;
    for (int k = 0; k < N_CH; k++) begin
      search_idx = CH_W'((32'(rr_ptr_reg) + 32'(k)) % 32'(N_CH));
      if (!grant_found && cnt_nz[search_idx]) begin
        grant_found = 1'b1;
        grant_idx   = search_idx;
      end
    end
  end

  assign grant_idx_inc = (grant_idx == CH_LAST) ? '0 : grant_idx + CH_W'(1);

  // A new grant may be issued from IDLE, or on the handshake edge of an
  // offer; the latter gives back-to-back transfers one per cycle.
  assign grant_allowed = (state_reg == IDLE) || (evt_valid_reg && evt_ready);
  assign do_grant      = grant_allowed && grant_found;

  // Counter update. An edge and a grant on the same channel cancel out.
  // A decrement only happens on a granted channel, whose count is non-zero.
  always_comb begin
    pending_next = 1'b0;
    ovf_set      = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_next[i] = cnt_reg[i];
      if (edge_det[i] && !dec[i]) begin
        if (cnt_reg[i] == CNT_MAX) begin
          ovf_set[i] = 1'b1;
        end else begin
          cnt_next[i] = cnt_reg[i] + CNT_W'(1);
        end
      end else if (!edge_det[i] && dec[i]) begin
        cnt_next[i] = cnt_reg[i] - CNT_W'(1);
      end
      if (cnt_next[i] != '0) begin
        pending_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d0_reg          <= '0;
      d1_reg          <= '0;
      overflow_reg    <= '0;
      pending_any_reg <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_reg[i] <= '0;
      end
    end else begin
      d0_reg          <= sig_in;
      d1_reg          <= d0_reg;
      // Saturation set wins over a clear pulse in the same cycle.
      overflow_reg    <= ovf_set | (overflow_reg & ~ovf_clr);
      pending_any_reg <= pending_next;
      for (int i = 0; i < N_CH; i++) begin
        cnt_reg[i] <= cnt_next[i];
      end
    end
  end

  // Offer FSM. A reset in the middle of an offer drops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      evt_valid_reg <= 1'b0;
      evt_ch_reg    <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (do_grant) begin
            evt_valid_reg <= 1'b1;
            evt_ch_reg    <= grant_idx;
            rr_ptr_reg    <= grant_idx_inc;
            state_reg     <= OFFER;
          end
        end
        OFFER: begin
          if (evt_valid_reg && evt_ready) begin
            if (grant_found) begin
              evt_ch_reg <= grant_idx;
              rr_ptr_reg <= grant_idx_inc;
            end else begin
              evt_valid_reg <= 1'b0;
              state_reg     <= IDLE;
            end
          end
        end
        default: begin
          evt_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_scheduler.sv
// ----------------------------------------------------------------------------
// tb_edge_event_scheduler
//
// Self-checking bench for edge_event_scheduler (N_CH=4, CNT_W=2 so that
// saturation is reached quickly). A behavioural model tracks per-channel
// pending counts as integers and pushes the channel it expects to be offered
// into a queue; a separate monitor compares every accepted DUT event against
// the queue and checks evt_valid, pending_any and overflow each cycle.
// ----------------------------------------------------------------------------
module tb_edge_event_scheduler;

  localparam int N    = 4;
  localparam int CMAX = 3;

  logic       clk;
  logic       reset;
  logic [3:0] sig_in;
  logic [3:0] ch_en;
  logic       evt_valid;
  logic [1:0] evt_ch;
  logic       evt_ready;
  logic       pending_any;
  logic [3:0] overflow;
  logic [3:0] ovf_clr;

  int n_checks;
  int n_fail;
  int n_delivered;

  // Reference model state
  int m_cnt [N];
  bit m_ovf [N];
  bit m_prev0 [N];
  bit m_prev1 [N];
  bit m_valid;
  int m_rr;
  bit m_pend;
  int exp_q [$];

  edge_event_scheduler #(
    .N_CH  (4),
    .CNT_W (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sig_in      (sig_in),
    .ch_en       (ch_en),
    .evt_valid   (evt_valid),
    .evt_ch      (evt_ch),
    .evt_ready   (evt_ready),
    .pending_any (pending_any),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: one step per rising clock, from the event-counting rules.
  initial begin
    int  g;
    bit  inc;
    bit  dec;
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < N; i++) begin
          m_cnt[i] = 0; m_ovf[i] = 0; m_prev0[i] = 0; m_prev1[i] = 0;
        end
        m_valid = 0; m_rr = 0; m_pend = 0;
        exp_q.delete();
      end else begin
        g = -1;
        if (!m_valid || evt_ready) begin
          for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (g < 0 && m_cnt[j] > 0) g = j;
          end
          if (g >= 0) begin
            exp_q.push_back(g);
            m_valid = 1;
            m_rr = (g + 1) % N;
          end else begin
            m_valid = 0;
          end
        end
        m_pend = 0;
        for (int i = 0; i < N; i++) begin
          inc = ch_en[i] && m_prev0[i] && !m_prev1[i];
          dec = (g == i);
          if (ovf_clr[i]) m_ovf[i] = 0;
          if (inc && !dec) begin
            if (m_cnt[i] == CMAX) m_ovf[i] = 1;
            else m_cnt[i] = m_cnt[i] + 1;
          end else if (dec && !inc) begin
            m_cnt[i] = m_cnt[i] - 1;
          end
          if (m_cnt[i] > 0) m_pend = 1;
          m_prev1[i] = m_prev0[i];
          m_prev0[i] = sig_in[i];
        end
      end
    end
  end

  // Monitor: sample away from the active edge and score accepted events.
  initial begin
    int e;
    logic [3:0] ovf_exp;
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) ovf_exp[i] = m_ovf[i];
      chk("evt_valid", int'(evt_valid), int'(m_valid));
      chk("pending_any", int'(pending_any), int'(m_pend));
      chk("overflow", int'(overflow), int'(ovf_exp));
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_nonempty", 0, 1);
        end else begin
          e = exp_q.pop_front();
          chk("evt_ch", int'(evt_ch), e);
          n_delivered++;
          if (!reset) $display("event: ch=%0d at %0t", evt_ch, $time);
        end
      end
    end
  end

  // One call = one clock cycle of input values.
  task automatic drive(input logic [3:0] s, input logic [3:0] en, input logic r,
                       input logic [3:0] clr, input logic rst);
    @(posedge clk);
    #1;
    sig_in = s; ch_en = en; evt_ready = r; ovf_clr = clr; reset = rst;
  endtask

  task automatic pulses(input logic [3:0] s, input logic [3:0] en, input logic r,
                        input int n);
    for (int p = 0; p < n; p++) begin
      drive(s, en, r, 4'h0, 1'b0);
      drive(4'h0, en, r, 4'h0, 1'b0);
      drive(4'h0, en, r, 4'h0, 1'b0);
    end
  endtask

  initial begin
    logic [3:0] rs;
    bit drained;
    n_checks = 0; n_fail = 0; n_delivered = 0;
    sig_in = 4'h0; ch_en = 4'hF; evt_ready = 1'b1; ovf_clr = 4'h0; reset = 1'b1;

    // Single rising edge on channel 2
    repeat (3) drive(4'h0, 4'hF, 1'b1, 4'h0, 1'b1);
    drive(4'h0, 4'hF, 1'b1, 4'h0, 1'b0);
    repeat (8) drive(4'h4, 4'hF, 1'b1, 4'h0, 1'b0);
    drive(4'h0, 4'hF, 1'b1, 4'h0, 1'b0);

    // Three pulses on ch0 with the consumer stalled, then released
    pulses(4'h1, 4'hF, 1'b0, 3);
    repeat (3) drive(4'h0, 4'hF, 1'b0, 4'h0, 1'b0);
    repeat (6) drive(4'h0, 4'hF, 1'b1, 4'h0, 1'b0);

    // All channels rise together, twice
    repeat (6) drive(4'hF, 4'hF, 1'b1, 4'h0, 1'b0);
    repeat (2) drive(4'h0, 4'hF, 1'b1, 4'h0, 1'b0);
    repeat (8) drive(4'hF, 4'hF, 1'b1, 4'h0, 1'b0);
    repeat (2) drive(4'h0, 4'hF, 1'b1, 4'h0, 1'b0);

    // Saturation on ch1, clear, then clear colliding with a saturating edge
    pulses(4'h2, 4'hF, 1'b0, 5);
    drive(4'h0, 4'hF, 1'b0, 4'h2, 1'b0);
    drive(4'h0, 4'hF, 1'b0, 4'h0, 1'b0);
    drive(4'h2, 4'hF, 1'b0, 4'h0, 1'b0);
    drive(4'h0, 4'hF, 1'b0, 4'h2, 1'b0);
    repeat (2) drive(4'h0, 4'hF, 1'b0, 4'h0, 1'b0);
    repeat (6) drive(4'h0, 4'hF, 1'b1, 4'h0, 1'b0);

    // Disabled channel 3: new edges dropped, pending ones still delivered
    pulses(4'h8, 4'h7, 1'b1, 2);
    pulses(4'h8, 4'hF, 1'b0, 2);
    repeat (6) drive(4'h0, 4'h7, 1'b1, 4'h0, 1'b0);

    // Reset during an offer; ch1 held high through reset
    pulses(4'h1, 4'hF, 1'b0, 3);
    repeat (2) drive(4'h2, 4'hF, 1'b0, 4'h0, 1'b1);
    repeat (8) drive(4'h2, 4'hF, 1'b1, 4'h0, 1'b0);

    // Randomised traffic
    rs = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      rs = rs ^ (4'($urandom) & 4'($urandom));
      drive(rs,
            ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0,
            ($urandom_range(0, 399) == 0));
    end

    // Drain with a bounded wait
    drained = 0;
    for (int c = 0; c < 100 && !drained; c++) begin
      drive(4'h0, 4'hF, 1'b1, 4'h0, 1'b0);
      if (exp_q.size() == 0 && !evt_valid && !m_valid) drained = 1;
    end
    repeat (3) drive(4'h0, 4'hF, 1'b1, 4'h0, 1'b0);
    @(negedge clk);
    chk("drain_complete", int'(drained), 1);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_evt_valid", int'(evt_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
